gshare_bht: RTL and testbench
=============================

// Module: gshare_bht
// PURPOSE
//  Parametrised gshare branch history table; successor to the PC-indexed 2-bit BHT in fetch.
//  Index = PC bits XOR speculative global history register (GHR); N-bit saturating counters.
//  Predicts in IF; trains and repairs GHR on branch resolution (EX).
//  Self-initialises the table after reset via a sweep FSM.
// PARAMETERS
//  SIZE       256  table entries; power of 2, >= 2
//  CTR_WIDTH  2    saturating counter width; 2..4
//  HIST_LEN   8    GHR length; 1..$clog2(SIZE)
//  IDX_OFFSET 2    PC LSB where index bits start (word-aligned PCs)
// PORTS
//  clk             in   1          clock
//  rst             in   1          synchronous, active-high reset
//  busy            out  1          init sweep in progress; predictions and updates ignored
//  bht_read        in   1          IF lookup valid this cycle
//  pc_address_read in   32         fetch PC
//  br_pred         out  1          predicted taken (counter MSB)
//  bht_rdata       out  CTR_WIDTH  counter value read; carried down pipe
//  bht_ridx        out  IDXW       hashed index used; carried down pipe (IDXW=$clog2(SIZE))
//  ghr_snap        out  HIST_LEN   GHR before this lookup's shift; carried down pipe
//  bht_write       in   1          resolved branch training strobe
//  upd_idx         in   IDXW       returned bht_ridx
//  bht_rdata_ret   in   CTR_WIDTH  returned bht_rdata
//  br_taken        in   1          resolved outcome
//  mispredict      in   1          resolved direction != br_pred; qualified by bht_write
//  ghr_ret         in   HIST_LEN   returned ghr_snap
// BEHAVIOUR
//  Reset: ghr=0, init_ptr=0, state=INIT, busy=1. rst mid-sweep or mid-run restarts INIT at 0.
//  INIT: writes WNT=2^(CTR_WIDTH-1)-1 to entry init_ptr each cycle. SIZE cycles, then READY, busy=0.
//  While busy: br_pred=0, bht_rdata=WNT, bht_ridx=0, ghr_snap=0. bht_read and bht_write ignored.
//  Lookup (combinational, 0-cycle):
//   - idx = pc_address_read[IDX_OFFSET +: IDXW] ^ {zero-pad, ghr}.
//   - bht_rdata = table[idx]; br_pred = bht_rdata[CTR_WIDTH-1].
//  Speculative GHR: bht_read && !busy && !(bht_write && mispredict) -> ghr <= {ghr[HIST_LEN-2:0], br_pred}.
//   For HIST_LEN=1: ghr <= br_pred.
//  Training, bht_write && !busy, at posedge:
//   - table[upd_idx] <= br_taken ? sat_inc(bht_rdata_ret) : sat_dec(bht_rdata_ret).
//   - Saturation: stays at 2^CTR_WIDTH-1 when incremented, stays at 0 when decremented.
//   - Uses the returned value only; the table is never re-read.
//  Recovery: bht_write && mispredict -> ghr <= {ghr_ret[HIST_LEN-2:0], br_taken}.
//   Beats the speculative shift in the same cycle.
//  Same-cycle write/read to the same idx: write-first bypass; bht_rdata and br_pred show the new value.
//  Same-cycle read/write to different idx: independent; no stall.
//  Outputs are combinational from table/ghr. No internal pipeline registers other than ghr, state, init_ptr.
// STRUCTURE
//  bht_pkg:
//   - typedef enum {INIT, READY} bht_state_t.
//   - functions sat_inc/sat_dec(ctr, width).
//   - function wnt(width).
//  Sub-module bht_ctr_array #(SIZE, CTR_WIDTH): 1 async read port, 1 sync write port, no reset.
//   Init writes are muxed onto its write port.
//  Top holds: hash, GHR, init FSM, bypass mux.
// TESTING
//  1. rst 1 cycle -> busy=1 for exactly SIZE cycles.
//     Then every entry reads 01 (CTR_WIDTH=2); br_pred=0; ghr=0.
//  2. Same branch PC=0x100, taken, trained 3x with GHR held at 0.
//     Counter goes 01->10->11->11 (saturates); br_pred=1 after the first update.
//  3. Lookups with predictions 1,0,1 -> ghr=3'b101 (low bits).
//     bht_ridx = PC[9:2]^8'h05 for the next lookup.
//  4. Mispredict with ghr_ret=8'h3C, br_taken=1, concurrent bht_read.
//     ghr=8'h79 next cycle; speculative shift suppressed.
//  5. bht_write and bht_read hit the same idx in one cycle, counter 01->10.
//     bht_rdata=10 and br_pred=1 in that cycle.
//  6. rst asserted at init_ptr=100 -> sweep restarts at 0.
//     Writes during busy leave the table at WNT; repeat with CTR_WIDTH=3 and WNT=011.

Source files
------------

// File: rtl/bht_pkg.sv
// Shared types and counter helpers for the gshare branch history table.
package bht_pkg;

    typedef enum logic {INIT, READY} bht_state_t;

    // Counters are handled in a 4-bit container; callers keep the low CTR_WIDTH bits.
    function automatic logic [3:0] sat_inc(input logic [3:0] ctr, input int width);
        logic [3:0] maxv;
        maxv = 4'((1 << width) - 1);
        return (ctr >= maxv) ? ctr : ctr + 4'd1;
    endfunction

    function automatic logic [3:0] sat_dec(input logic [3:0] ctr, input int width);
        logic [3:0] maxv;
        maxv = 4'((1 << width) - 1);
        return (ctr == 4'd0) ? 4'd0 : ((ctr - 4'd1) & maxv);
    endfunction

    function automatic logic [3:0] wnt(input int width);
        return 4'((1 << (width - 1)) - 1);
    endfunction

endpackage

// File: rtl/bht_ctr_array.sv
// Counter storage: one asynchronous read port, one synchronous write port, no reset.
module bht_ctr_array #(
    parameter int SIZE      = 256,
    parameter int CTR_WIDTH = 2,
    localparam int IDXW     = $clog2(SIZE)
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [IDXW-1:0]      i_waddr,
    input  logic [CTR_WIDTH-1:0] i_wdata,
    input  logic [IDXW-1:0]      i_raddr,
    output logic [CTR_WIDTH-1:0] o_rdata
);

    logic [CTR_WIDTH-1:0] r_mem [SIZE];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/gshare_bht.sv
// Gshare predictor: PC^GHR hashed lookup, speculative GHR with mispredict repair, init sweep.
module gshare_bht
    import bht_pkg::*;
#(
    parameter int SIZE       = 256,
    parameter int CTR_WIDTH  = 2,
    parameter int HIST_LEN   = 8,
    parameter int IDX_OFFSET = 2,
    localparam int IDXW      = $clog2(SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 busy,
    input  logic                 bht_read,
    input  logic [31:0]          pc_address_read,
    output logic                 br_pred,
    output logic [CTR_WIDTH-1:0] bht_rdata,
    output logic [IDXW-1:0]      bht_ridx,
    output logic [HIST_LEN-1:0]  ghr_snap,
    input  logic                 bht_write,
    input  logic [IDXW-1:0]      upd_idx,
    input  logic [CTR_WIDTH-1:0] bht_rdata_ret,
    input  logic                 br_taken,
    input  logic                 mispredict,
    input  logic [HIST_LEN-1:0]  ghr_ret
);

    localparam logic [CTR_WIDTH-1:0] WNT = CTR_WIDTH'(wnt(CTR_WIDTH));

    bht_state_t           r_state, w_nextState;
    logic [IDXW-1:0]      r_initPtr, w_nextPtr;
    logic [HIST_LEN-1:0]  r_ghr, w_specGhr, w_recGhr;
    logic                 w_busy;
    logic [IDXW-1:0]      w_ghrExt, w_idx;
    logic [3:0]           w_retExt, w_incFull, w_decFull;
    logic [CTR_WIDTH-1:0] w_trainVal, w_arrRdata, w_lookup, w_wdata;
    logic [IDXW-1:0]      w_waddr;
    logic                 w_we, w_bypass, w_pred;
    logic                 w_unusedBits;

    assign w_busy = (r_state == INIT);

    always_comb begin
        w_nextState = r_state;
        w_nextPtr   = r_initPtr;
        if (r_state == INIT) begin
            w_nextPtr = r_initPtr + IDXW'(1);
            if (r_initPtr == IDXW'(SIZE - 1)) w_nextState = READY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= INIT;
            r_initPtr <= '0;
        end else begin
            r_state   <= w_nextState;
            r_initPtr <= w_nextPtr;
        end
    end

    always_comb begin
        w_ghrExt                 = '0;
        w_ghrExt[HIST_LEN-1:0]   = r_ghr;
        w_retExt                 = '0;
        w_retExt[CTR_WIDTH-1:0]  = bht_rdata_ret;
    end

    assign w_idx      = pc_address_read[IDX_OFFSET +: IDXW] ^ w_ghrExt;
    assign w_incFull  = sat_inc(w_retExt, CTR_WIDTH);
    assign w_decFull  = sat_dec(w_retExt, CTR_WIDTH);
    assign w_trainVal = br_taken ? w_incFull[CTR_WIDTH-1:0] : w_decFull[CTR_WIDTH-1:0];

    // The sweep owns the write port while busy; training is only accepted afterwards.
    assign w_we    = w_busy | bht_write;
    assign w_waddr = w_busy ? r_initPtr : upd_idx;
    assign w_wdata = w_busy ? WNT : w_trainVal;

    bht_ctr_array #(
        .SIZE      (SIZE),
        .CTR_WIDTH (CTR_WIDTH)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_idx),
        .o_rdata (w_arrRdata)
    );

    assign w_bypass = bht_write && !w_busy && (upd_idx == w_idx);
    assign w_lookup = w_bypass ? w_trainVal : w_arrRdata;
    assign w_pred   = w_lookup[CTR_WIDTH-1];

    assign busy      = w_busy;
    assign br_pred   = !w_busy && w_pred;
    assign bht_rdata = w_busy ? WNT : w_lookup;
    assign bht_ridx  = w_busy ? '0 : w_idx;
    assign ghr_snap  = w_busy ? '0 : r_ghr;

    generate
        if (HIST_LEN == 1) begin : g_hist1
            assign w_specGhr = w_pred;
            assign w_recGhr  = br_taken;
        end else begin : g_histN
            assign w_specGhr = {r_ghr[HIST_LEN-2:0], w_pred};
            assign w_recGhr  = {ghr_ret[HIST_LEN-2:0], br_taken};
        end
    endgenerate

    // Repair from the resolved branch takes priority over this cycle's speculative shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ghr <= '0;
        end else if (!w_busy) begin
            if (bht_write && mispredict) r_ghr <= w_recGhr;
            else if (bht_read)           r_ghr <= w_specGhr;
        end
    end

    assign w_unusedBits = ^{w_incFull, w_decFull, pc_address_read, ghr_ret};

endmodule

// File: tb/tb_gshare_bht.sv
// Scoreboard bench for gshare_bht: stimulus queues expectations, a negedge monitor checks them.
module tb_gshare_bht;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, busy, bht_read, br_pred, bht_write, br_taken, mispredict;
   logic [31:0] pc_address_read;
   logic [1:0]  bht_rdata, bht_rdata_ret;
   logic [7:0]  bht_ridx, ghr_snap, upd_idx, ghr_ret;

   logic        rstB, busyB, readB, predB, writeB, takenB, mispB;
   logic [31:0] pcB;
   logic [2:0]  rdataB, retB;
   logic [3:0]  ridxB, ghrSnapB, updIdxB, ghrRetB;

   gshare_bht #(.SIZE(256), .CTR_WIDTH(2), .HIST_LEN(8), .IDX_OFFSET(2)) dutA (
      .clk(clk), .rst(rst), .busy(busy), .bht_read(bht_read),
      .pc_address_read(pc_address_read), .br_pred(br_pred), .bht_rdata(bht_rdata),
      .bht_ridx(bht_ridx), .ghr_snap(ghr_snap), .bht_write(bht_write),
      .upd_idx(upd_idx), .bht_rdata_ret(bht_rdata_ret), .br_taken(br_taken),
      .mispredict(mispredict), .ghr_ret(ghr_ret)
   );

   gshare_bht #(.SIZE(16), .CTR_WIDTH(3), .HIST_LEN(4), .IDX_OFFSET(2)) dutB (
      .clk(clk), .rst(rstB), .busy(busyB), .bht_read(readB),
      .pc_address_read(pcB), .br_pred(predB), .bht_rdata(rdataB),
      .bht_ridx(ridxB), .ghr_snap(ghrSnapB), .bht_write(writeB),
      .upd_idx(updIdxB), .bht_rdata_ret(retB), .br_taken(takenB),
      .mispredict(mispB), .ghr_ret(ghrRetB)
   );

   typedef struct {
      string name;
      int    kind;
      int    exp;
   } expT;

   expT sbq[$];
   int  total = 0;
   int  bad   = 0;

   function automatic int actualOf(input int kind);
      case (kind)
         0:  return int'(busy);
         1:  return int'(br_pred);
         2:  return int'(bht_rdata);
         3:  return int'(bht_ridx);
         4:  return int'(ghr_snap);
         10: return int'(busyB);
         11: return int'(predB);
         12: return int'(rdataB);
         13: return int'(ridxB);
         14: return int'(ghrSnapB);
         default: return -1;
      endcase
   endfunction

   // Monitor: drains everything queued for the current cycle at the falling edge.
   always @(negedge clk) begin
      expT e;
      int  act;
      while (sbq.size() > 0) begin
         e   = sbq.pop_front();
         act = actualOf(e.kind);
         total++;
         if (act != e.exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", e.name, act, e.exp);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int kind, input int exp);
      expT e;
      e.name = name;
      e.kind = kind;
      e.exp  = exp;
      sbq.push_back(e);
   endtask

   task automatic applyStimulus(input logic rd, input logic [31:0] pc, input logic wr,
                                input logic [7:0] idx, input logic [1:0] ret,
                                input logic tk, input logic mp, input logic [7:0] gr);
      bht_read = rd; pc_address_read = pc; bht_write = wr; upd_idx = idx;
      bht_rdata_ret = ret; br_taken = tk; mispredict = mp; ghr_ret = gr;
   endtask

   task automatic applyStimulusB(input logic rd, input logic [31:0] pc, input logic wr,
                                 input logic [3:0] idx, input logic [2:0] ret, input logic tk);
      readB = rd; pcB = pc; writeB = wr; updIdxB = idx; retB = ret;
      takenB = tk; mispB = 1'b0; ghrRetB = 4'h0;
   endtask

   // Watchdog: aborts the run if the main sequence never completes.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: init sweep, training, speculation, repair, bypass and mid-sweep reset.
   initial begin
      rst = 1'b1; rstB = 1'b1;
      applyStimulus(0, 32'h0, 0, 8'h00, 2'd0, 0, 0, 8'h00);
      applyStimulusB(0, 32'h0, 0, 4'h0, 3'd0, 0);
      tick();
      rst = 1'b0; rstB = 1'b0;

      for (int i = 0; i <= 256; i++) begin
         if (i < 256) applyStimulus(1, 32'h3FC, 0, 8'h00, 2'd0, 0, 0, 8'h00);
         else         applyStimulus(0, 32'h3FC, 0, 8'h00, 2'd0, 0, 0, 8'h00);
         if (i < 15)  applyStimulusB(0, 32'h0, 1, 4'h5, 3'd7, 1);
         else         applyStimulusB(0, 32'h0, 0, 4'h0, 3'd0, 0);
         if (i == 0) begin
            checkOutput("init_busy0", 0, 1);
            checkOutput("init_rdata_wnt", 2, 1);
            checkOutput("init_pred0", 1, 0);
            checkOutput("init_ridx0", 3, 0);
            checkOutput("init_ghr0", 4, 0);
            checkOutput("B_init_rdata_wnt", 12, 3);
         end
         if (i == 15)  checkOutput("B_busy_last", 10, 1);
         if (i == 16)  checkOutput("B_ready", 10, 0);
         if (i == 255) checkOutput("init_busy_last", 0, 1);
         if (i == 256) checkOutput("init_ready", 0, 0);
         if (i < 256) tick();
      end

      applyStimulus(0, 32'h0, 0, 8'h00, 2'd0, 0, 0, 8'h00);
      checkOutput("post_ridx0", 3, 0);
      checkOutput("post_rdata0", 2, 1);
      checkOutput("post_pred0", 1, 0);
      checkOutput("post_ghr", 4, 0);
      #1;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL direct_busy_ready: got %0d expected 0", busy);
      end
      total++;
      if (bht_ridx !== 8'h00) begin
         bad++;
         $display("[TB] FAIL direct_post_ridx0: got %0d expected 0", bht_ridx);
      end
      tick();
      applyStimulus(0, 32'h3FC, 0, 8'h00, 2'd0, 0, 0, 8'h00);
      checkOutput("post_ridxFF", 3, 255);
      checkOutput("post_rdataFF", 2, 1);
      tick();

      applyStimulusB(0, 32'h14, 0, 4'h0, 3'd0, 0);
      checkOutput("B_ridx5", 13, 5);
      checkOutput("B_rdata5_wnt", 12, 3);
      checkOutput("B_pred5", 11, 0);
      checkOutput("B_ghr0", 14, 0);
      #1;
      total++;
      if (rdataB !== 3'd3) begin
         bad++;
         $display("[TB] FAIL direct_B_rdata5_wnt: got %0d expected 3", rdataB);
      end
      tick();
      applyStimulusB(0, 32'h3C, 0, 4'h0, 3'd0, 0);
      checkOutput("B_rdata15_wnt", 12, 3);
      tick();
      applyStimulusB(0, 32'h14, 1, 4'h5, 3'd3, 1);
      checkOutput("B_bypass_inc", 12, 4);
      checkOutput("B_bypass_pred", 11, 1);
      tick();
      applyStimulusB(0, 32'h14, 0, 4'h0, 3'd0, 0);
      checkOutput("B_stored4", 12, 4);
      tick();
      applyStimulusB(0, 32'h14, 1, 4'h5, 3'd7, 1);
      checkOutput("B_sat_hi", 12, 7);
      tick();
      applyStimulusB(0, 32'h14, 1, 4'h5, 3'd0, 0);
      checkOutput("B_sat_lo", 12, 0);
      tick();
      applyStimulusB(0, 32'h14, 0, 4'h0, 3'd0, 0);
      checkOutput("B_stored0", 12, 0);
      checkOutput("B_stored0_pred", 11, 0);
      tick();

      applyStimulus(0, 32'h0, 1, 8'h40, 2'd1, 1, 0, 8'h00);
      tick();
      applyStimulus(0, 32'h100, 0, 8'h00, 2'd0, 0, 0, 8'h00);
      checkOutput("train1_ridx", 3, 8'h40);
      checkOutput("train1_rdata", 2, 2);
      checkOutput("train1_pred", 1, 1);
      checkOutput("train1_ghr", 4, 0);
      tick();
      applyStimulus(0, 32'h0, 1, 8'h40, 2'd2, 1, 0, 8'h00);
      tick();
      applyStimulus(0, 32'h100, 0, 8'h00, 2'd0, 0, 0, 8'h00);
      checkOutput("train2_rdata", 2, 3);
      tick();
      applyStimulus(0, 32'h0, 1, 8'h40, 2'd3, 1, 0, 8'h00);
      tick();
      applyStimulus(0, 32'h100, 0, 8'h00, 2'd0, 0, 0, 8'h00);
      checkOutput("train3_sat", 2, 3);
      checkOutput("train3_pred", 1, 1);
      tick();

      applyStimulus(1, 32'h100, 0, 8'h00, 2'd0, 0, 0, 8'h00);
      checkOutput("spec1_pred", 1, 1);
      tick();
      applyStimulus(1, 32'h0, 0, 8'h00, 2'd0, 0, 0, 8'h00);
      checkOutput("spec2_ridx", 3, 8'h01);
      checkOutput("spec2_pred", 1, 0);
      tick();
      applyStimulus(1, 32'h108, 0, 8'h00, 2'd0, 0, 0, 8'h00);
      checkOutput("spec3_ridx", 3, 8'h40);
      checkOutput("spec3_pred", 1, 1);
      tick();
      applyStimulus(0, 32'h200, 0, 8'h00, 2'd0, 0, 0, 8'h00);
      checkOutput("spec_ghr101", 4, 8'h05);
      checkOutput("spec_ridx85", 3, 8'h85);
      tick();

      applyStimulus(1, 32'h0, 1, 8'h10, 2'd1, 1, 1, 8'h3C);
      tick();
      applyStimulus(0, 32'h1A4, 0, 8'h00, 2'd0, 0, 0, 8'h00);
      checkOutput("repair_ghr", 4, 8'h79);
      checkOutput("repair_ridx", 3, 8'h10);
      checkOutput("repair_trained", 2, 2);
      #1;
      total++;
      if (ghr_snap !== 8'h79) begin
         bad++;
         $display("[TB] FAIL direct_repair_ghr: got %0h expected 79", ghr_snap);
      end
      tick();

      applyStimulus(1, 32'h0, 1, 8'h79, 2'd1, 1, 0, 8'h00);
      checkOutput("bypass_ridx", 3, 8'h79);
      checkOutput("bypass_rdata", 2, 2);
      checkOutput("bypass_pred", 1, 1);
      #1;
      total++;
      if (bht_rdata !== 2'd2) begin
         bad++;
         $display("[TB] FAIL direct_bypass_rdata: got %0d expected 2", bht_rdata);
      end
      tick();
      applyStimulus(0, 32'h0, 1, 8'h20, 2'd0, 0, 0, 8'h00);
      checkOutput("bypass_ghr", 4, 8'hF3);
      checkOutput("indep_ridx", 3, 8'hF3);
      checkOutput("indep_rdata", 2, 1);
      tick();
      applyStimulus(0, 32'h228, 0, 8'h00, 2'd0, 0, 0, 8'h00);
      checkOutput("bypass_stored", 2, 2);
      tick();
      applyStimulus(0, 32'h34C, 0, 8'h00, 2'd0, 0, 0, 8'h00);
      checkOutput("dec_floor", 2, 0);
      checkOutput("dec_floor_pred", 1, 0);
      tick();

      applyStimulus(0, 32'h0, 0, 8'h00, 2'd0, 0, 0, 8'h00);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 100; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i <= 256; i++) begin
         if (i < 255) applyStimulus(1, 32'h100, 1, 8'h40, 2'd3, 1, 0, 8'h00);
         else         applyStimulus(0, 32'h100, 0, 8'h00, 2'd0, 0, 0, 8'h00);
         if (i == 0)   checkOutput("rerst_busy0", 0, 1);
         if (i == 200) checkOutput("rerst_busy200", 0, 1);
         if (i == 255) checkOutput("rerst_busy_last", 0, 1);
         if (i == 256) checkOutput("rerst_ready", 0, 0);
         if (i < 256) tick();
      end
      checkOutput("rerst_ridx40", 3, 8'h40);
      checkOutput("rerst_rdata40", 2, 1);
      checkOutput("rerst_pred40", 1, 0);
      checkOutput("rerst_ghr", 4, 0);
      tick();
      applyStimulus(0, 32'h228, 0, 8'h00, 2'd0, 0, 0, 8'h00);
      checkOutput("rerst_rdata8A", 2, 1);
      tick();
      applyStimulus(0, 32'h34C, 0, 8'h00, 2'd0, 0, 0, 8'h00);
      checkOutput("rerst_rdataD3", 2, 1);
      tick();
      applyStimulus(0, 32'h40, 0, 8'h00, 2'd0, 0, 0, 8'h00);
      checkOutput("rerst_rdata10", 2, 1);
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
